// File: rtl/mdu_e.sv
// Iterative multiply/divide unit owning HI/LO; one bit per falling clock edge.
// Optional MDU_FAST_MUL_EN: single-cycle combinational multiply, divide unchanged.
module mdu_e #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t             state_q, state_d;
   logic [1:0]         op_q, op_d;
   logic               sa_q, sa_d, sb_q, sb_d;
   logic               dz_q, dz_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opb_q, opb_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic               done_q, done_d;

   logic               is_div, is_signed;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     msum, dtrial;
   logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   assign is_div    = op[1];
   assign is_signed = ~op[0];
   assign mag_a     = (is_signed && srca[WIDTH-1]) ? -srca : srca;
   assign mag_b     = (is_signed && srcb[WIDTH-1]) ? -srcb : srcb;

   // Multiply: acc = {partial product, remaining multiplier bits}
   assign msum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
   assign mul_next = acc_q[0] ? {msum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};

   // Divide: acc = {remainder, dividend bits shifting out / quotient bits shifting in}
   assign dtrial   = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opb_q};
   assign div_next = dtrial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                   : {dtrial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

   // Sign flags are only latched for signed ops, so fixups need no op decode here
   assign prod_fix = (sa_q ^ sb_q) ? -acc_q : acc_q;
   assign quo_fix  = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
   assign rem_fix  = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      dz_d    = dz_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      opb_d   = opb_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               op_d  = op;
               sa_d  = is_signed & srca[WIDTH-1];
               sb_d  = is_signed & srcb[WIDTH-1];
               cnt_d = CW'(WIDTH);
               dz_d  = 1'b0;
               if (is_div && (srcb == '0)) begin
                  dz_d    = 1'b1;
                  acc_d   = {srca, {WIDTH{1'b1}}};
                  state_d = FIX;
               end else if (is_div) begin
                  opb_d   = mag_b;
                  acc_d   = {{WIDTH{1'b0}}, mag_a};
                  state_d = CALC;
               end else begin
`ifdef MDU_FAST_MUL_EN
                  opb_d   = mag_a;
                  acc_d   = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
                  state_d = FIX;
`else
                  opb_d   = mag_a;
                  acc_d   = {{WIDTH{1'b0}}, mag_b};
                  state_d = CALC;
`endif
               end
            end else begin
               if (mthi) hi_d = srca;
               if (mtlo) lo_d = srca;
            end
         end
         CALC: begin
            if (abort) begin
               state_d = IDLE;
            end else begin
               acc_d = op_q[1] ? div_next : mul_next;
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) state_d = FIX;
            end
         end
         FIX: begin
            state_d = IDLE;
            if (!abort) begin
               done_d = 1'b1;
               if (dz_q) begin
                  hi_d = acc_q[2*WIDTH-1:WIDTH];
                  lo_d = acc_q[WIDTH-1:0];
               end else if (op_q[1]) begin
                  hi_d = rem_fix;
                  lo_d = quo_fix;
               end else begin
                  hi_d = prod_fix[2*WIDTH-1:WIDTH];
                  lo_d = prod_fix[WIDTH-1:0];
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State advances on the falling edge, in step with the pipeline registers
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         dz_q    <= 1'b0;
         cnt_q   <= '0;
         acc_q   <= '0;
         opb_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         dz_q    <= dz_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         opb_q   <= opb_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_e.sv
// Directed bench for mdu_e: arithmetic results, latency, HI/LO moves, abort and reset.
module tb_mdu_e;
   logic        clk;
   logic        rst_n;
   logic        start;
   logic [1:0]  op;
   logic [31:0] srca, srcb;
   logic        mthi, mtlo, abort;
   logic        busy, done;
   logic [31:0] hi, lo;

   int errors = 0;
   int checks = 0;

   mdu_e #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .srca(srca), .srcb(srcb),
      .mthi(mthi), .mtlo(mtlo), .abort(abort), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: observed=running required=finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // DUT updates on falling edges; inputs change and outputs are sampled 2ns after
   task automatic edge_();
      @(negedge clk);
      #2;
   endtask

   task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic with_mtlo);
      start = 1'b1; op = o; srca = a; srcb = b; mtlo = with_mtlo;
      edge_();
      start = 1'b0; mtlo = 1'b0;
   endtask

   task automatic finish(input string tag, input logic [31:0] eh, input logic [31:0] el,
                         input int elat);
      int n;
      n = 0;
      do begin
         edge_();
         n++;
      end while (!done && n < 40);
      chk({tag, "_lat"}, 64'(n), 64'(elat));
      chk({tag, "_hi"}, {32'h0, hi}, {32'h0, eh});
      chk({tag, "_lo"}, {32'h0, lo}, {32'h0, el});
      chk({tag, "_idle"}, {63'h0, busy}, 64'h0);
      edge_();
      chk({tag, "_pulse"}, {63'h0, done}, 64'h0);
   endtask

   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                         input int elat);
      launch(o, a, b, 1'b0);
      chk({tag, "_busy"}, {63'h0, busy}, 64'h1);
      finish(tag, eh, el, elat);
   endtask

   initial begin
      logic seen_done;
      rst_n = 1'b0; start = 1'b0; op = 2'b00; srca = '0; srcb = '0;
      mthi = 1'b0; mtlo = 1'b0; abort = 1'b0;
      #3;
      chk("rst_busy", {63'h0, busy}, 64'h0);
      chk("rst_done", {63'h0, done}, 64'h0);
      chk("rst_hilo", {hi, lo}, 64'h0);
      edge_();
      rst_n = 1'b1;
      edge_();

      run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33);
      run_op("mult_neg",  2'b00, 32'hFFFFFFF9, 32'h00000006, 32'hFFFFFFFF, 32'hFFFFFFD6, 33);
      run_op("mult_nn",   2'b00, 32'hFFFFFFFD, 32'hFFFFFFFC, 32'h00000000, 32'h0000000C, 33);
      run_op("div_neg",   2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
      run_op("div_negb",  2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33);
      run_op("divu",      2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 33);
      run_op("divu_zero", 2'b11, 32'h00001234, 32'h0, 32'h00001234, 32'hFFFFFFFF, 1);
      run_op("div_ovf",   2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33);

      mthi = 1'b1; srca = 32'hAAAA5555;
      edge_();
      mthi = 1'b0;
      chk("mthi_hi", {32'h0, hi}, {32'h0, 32'hAAAA5555});
      chk("mthi_lo", {32'h0, lo}, {32'h0, 32'h80000000});

      mthi = 1'b1; mtlo = 1'b1; srca = 32'h13579BDF;
      edge_();
      mthi = 1'b0; mtlo = 1'b0;
      chk("mtboth", {hi, lo}, {32'h13579BDF, 32'h13579BDF});

      launch(2'b01, 32'd3, 32'd5, 1'b0);
      repeat (3) edge_();
      mtlo = 1'b1; srca = 32'hDEADBEEF;
      edge_();
      mtlo = 1'b0;
      chk("mtlo_calc", {32'h0, lo}, {32'h0, 32'h13579BDF});
      finish("mtlo_calc_res", 32'h0, 32'd15, 29);

      launch(2'b11, 32'd100, 32'd7, 1'b1);
      chk("start_mtlo_lo", {32'h0, lo}, {32'h0, 32'd15});
      chk("start_mtlo_busy", {63'h0, busy}, 64'h1);
      finish("start_mtlo_res", 32'd2, 32'd14, 33);

      mthi = 1'b1; srca = 32'd1;
      edge_();
      mthi = 1'b0; mtlo = 1'b1; srca = 32'd2;
      edge_();
      mtlo = 1'b0;
      launch(2'b00, 32'd5, 32'd5, 1'b0);
      seen_done = 1'b0;
      for (int i = 0; i < 9; i++) begin
         edge_();
         seen_done |= done;
      end
      abort = 1'b1;
      edge_();
      abort = 1'b0;
      seen_done |= done;
      chk("abort_busy", {63'h0, busy}, 64'h0);
      chk("abort_hilo", {hi, lo}, {32'd1, 32'd2});
      for (int i = 0; i < 40; i++) begin
         edge_();
         seen_done |= done;
      end
      chk("abort_nodone", {63'h0, seen_done}, 64'h0);
      chk("abort_hilo_late", {hi, lo}, {32'd1, 32'd2});

      launch(2'b11, 32'd100, 32'd7, 1'b0);
      repeat (5) edge_();
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", {63'h0, busy}, 64'h0);
      chk("midrst_done", {63'h0, done}, 64'h0);
      chk("midrst_hilo", {hi, lo}, 64'h0);
      edge_();
      rst_n = 1'b1;
      edge_();
      run_op("post_rst", 2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 33);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
